candidate_gen: RTL

- Upstream stage of the password cracker; feeds the index-to-ASCII character converter.
- Enumerates every 4-character lowercase candidate, "aaaa" through "zzzz".
- The candidate is a 4-digit base-26 odometer. Outputs a, b, c and d are letter indices 0..25, with d the least significant digit.
- Candidates are issued over a valid/ready handshake. Enumeration halts on a match from the comparator or when the keyspace is exhausted.

---
 rtl/candidate_gen_pkg.sv | 29 ++
 rtl/candidate_gen_if.sv | 41 ++++
 rtl/candidate_gen_digit_ctr.sv | 45 ++++
 rtl/candidate_gen.sv | 132 +++++++++++++
 4 files changed

// File: rtl/candidate_gen_pkg.sv
//------------------------------------------------------------------------------
// Module   : candidate_gen_pkg
// Purpose  : Shared constants and state encoding for the candidate generator.
//            ALPHA    - symbols per digit (lowercase alphabet)
//            IDX_W    - width of one digit index
//            CNT_W    - width of the accepted-candidate counter
//            LAST_IDX - largest digit value
//            KEYSPACE - number of 4-character candidates
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package candidate_gen_pkg;

  localparam int unsigned ALPHA    = 26;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned CNT_W    = 19;
  localparam int unsigned LAST_IDX = ALPHA - 1;
  localparam int unsigned KEYSPACE = ALPHA ** 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/candidate_gen_if.sv
//------------------------------------------------------------------------------
// Module   : candidate_gen_if
// Purpose  : Control and candidate-stream bundle between the generator and
//            its neighbours (comparator for stop, converter for the stream).
// Ports    : start, stop, out_ready       - into the generator
//            out_valid, a, b, c, d         - candidate stream out
//            busy, done, cnt               - status out
//            modport master : generator side
//            modport slave  : controller / downstream side
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface candidate_gen_if;
  import candidate_gen_pkg::*;

  logic             start;
  logic             stop;
  logic             out_ready;
  logic             out_valid;
  logic [IDX_W-1:0] a;
  logic [IDX_W-1:0] b;
  logic [IDX_W-1:0] c;
  logic [IDX_W-1:0] d;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt;

  modport master (
    input  start, stop, out_ready,
    output out_valid, a, b, c, d, busy, done, cnt
  );

  modport slave (
    output start, stop, out_ready,
    input  out_valid, a, b, c, d, busy, done, cnt
  );

endinterface

`default_nettype wire

// File: rtl/candidate_gen_digit_ctr.sv
//------------------------------------------------------------------------------
// Module   : candidate_gen_digit_ctr
// Purpose  : One base-ALPHA digit of the candidate odometer.
// Ports    : clk       in  system clock
//            rst       in  asynchronous active-low reset
//            clr       in  synchronous clear to 0 (wins over inc)
//            inc       in  advance by one, wrapping ALPHA-1 -> 0
//            val       out current digit value
//            carry_out out inc while at ALPHA-1 (advances next digit)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module candidate_gen_digit_ctr #(
  parameter int unsigned ALPHA = candidate_gen_pkg::ALPHA
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr,
  input  logic                                inc,
  output logic [candidate_gen_pkg::IDX_W-1:0] val,
  output logic                                carry_out
);
  import candidate_gen_pkg::*;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ALPHA - 1);

  logic w_at_last;

  assign w_at_last = (val == LAST);
  assign carry_out = inc & w_at_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val <= '0;
    end else if (clr) begin
      val <= '0;
    end else if (inc) begin
      val <= w_at_last ? '0 : val + IDX_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/candidate_gen.sv
//------------------------------------------------------------------------------
// Module   : candidate_gen
// Purpose  : Enumerates all 4-letter candidates "aaaa".."zzzz" as a base-ALPHA
//            odometer (d least significant) over a valid/ready stream. Halts
//            on stop from the comparator or once the keyspace is exhausted.
// Ports    : clk  in  system clock
//            rst  in  asynchronous active-low reset
//            bus  candidate_gen_if.master
//                 start/stop/out_ready in; out_valid, a..d, busy, done, cnt out
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module candidate_gen #(
  parameter int unsigned ALPHA = candidate_gen_pkg::ALPHA
) (
  input  logic            clk,
  input  logic            rst,
  candidate_gen_if.master bus
);
  import candidate_gen_pkg::*;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ALPHA - 1);

  state_t r_state;

  logic w_run;
  logic w_fire;
  logic w_last;
  logic w_clr;
  logic w_inc;
  logic w_carry_d;
  logic w_carry_c;
  logic w_carry_b;
  logic w_unused_carry_a;

  assign w_run  = (r_state == RUN);
  assign w_fire = bus.out_valid & bus.out_ready;
  assign w_last = (bus.a == LAST) & (bus.b == LAST) &
                  (bus.c == LAST) & (bus.d == LAST);

  // Digits clear only on a start that is honoured (outside RUN).
  assign w_clr = bus.start & ~w_run;

  // A fire on the final candidate must not wrap the odometer: the digits
  // keep showing "zzzz" once the keyspace is exhausted. Stop discards the
  // concurrent transfer.
  assign w_inc = w_run & w_fire & ~bus.stop & ~w_last;

  candidate_gen_digit_ctr #(.ALPHA(ALPHA)) u_digit_d (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_clr),
    .inc       (w_inc),
    .val       (bus.d),
    .carry_out (w_carry_d)
  );

  candidate_gen_digit_ctr #(.ALPHA(ALPHA)) u_digit_c (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_clr),
    .inc       (w_carry_d),
    .val       (bus.c),
    .carry_out (w_carry_c)
  );

  candidate_gen_digit_ctr #(.ALPHA(ALPHA)) u_digit_b (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_clr),
    .inc       (w_carry_c),
    .val       (bus.b),
    .carry_out (w_carry_b)
  );

  // The most significant carry can never be taken because the last
  // candidate suppresses the increment.
  candidate_gen_digit_ctr #(.ALPHA(ALPHA)) u_digit_a (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_clr),
    .inc       (w_carry_b),
    .val       (bus.a),
    .carry_out (w_unused_carry_a)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.cnt       <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state       <= RUN;
            bus.out_valid <= 1'b1;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
            bus.cnt       <= '0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            r_state       <= IDLE;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
          end else if (w_fire) begin
            bus.cnt <= bus.cnt + CNT_W'(1);
            if (w_last) begin
              r_state       <= DONE;
              bus.out_valid <= 1'b0;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
            end
          end
        end
        default: begin
          r_state       <= IDLE;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
